config_bus_writer: RTL and testbench

- Master/producer side of the PL configuration bus (config_addr / 512-bit config_data) read by all register-decoding blocks (controller, servo, modulator configs).
- Takes a framed 32-bit word stream from the PS side: first word is the target address, the following words are data words 0..N-1.
- Publishes the assembled frame on the bus: data stable first, then the address for a fixed number of cycles, then the address returns to idle so decoders stop re-latching.

---
 rtl/config_bus_writer.sv | 176 +++++++++++++++++
 tb/tb_config_bus_writer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/config_bus_writer.sv
// config_bus_writer
//   Producer side of the PL configuration bus. Collects a framed 32-bit word
//   stream (address word, then up to DATA_WORDS data words) and publishes it
//   on config_addr/config_data. Data is settled first. The address is then
//   driven for HOLD_CYCLES cycles and returns to IDLE_ADDR, so decoders latch
//   each frame only once.
//
//   Optional build macro: CONFIG_BUS_FRAME_COUNT_EN adds the frame_count
//   output. It counts the frames that were actually driven on the bus.
//
// Ports
//   aclk, aresetn   clock, asynchronous active-low reset
//   s_axis_tdata    stream word (address word, then data words)
//   s_axis_tvalid   word valid
//   s_axis_tready   word accepted when tvalid & tready at a rising edge
//   s_axis_tlast    final word of a frame
//   config_addr     bus address, IDLE_ADDR unless publishing
//   config_data     bus data, word k at [32k+31:32k]
//   busy            frame in progress (collect, publish or gap)
//   err_overflow    sticky: frame carried more than DATA_WORDS data words
//   err_addr        sticky: frame address equalled IDLE_ADDR
//   clear_err       synchronous clear of both sticky flags (a set wins)
//   frame_count     (macro only) number of frames driven, wraps at 2^32
module config_bus_writer #(
    parameter int unsigned DATA_WORDS  = 16,
    parameter int unsigned HOLD_CYCLES = 2,
    parameter logic [31:0] IDLE_ADDR   = 32'h0000_0000
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [31:0]                s_axis_tdata,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic                       s_axis_tlast,
    output logic [31:0]                config_addr,
    output logic [32*DATA_WORDS-1:0]   config_data,
    output logic                       busy,
    output logic                       err_overflow,
    output logic                       err_addr,
    input  logic                       clear_err
`ifdef CONFIG_BUS_FRAME_COUNT_EN
    ,
    output logic [31:0]                frame_count
`endif
);

    localparam int unsigned IDX_W = $clog2(DATA_WORDS + 1);
    localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_PUBLISH,
        S_GAP
    } state_t;

    state_t                     r_state;
    logic [31:0]                r_addr_pend;
    logic [IDX_W-1:0]           r_idx;
    logic [CNT_W-1:0]           r_hold;
    logic                       r_tready;
    logic [31:0]                r_config_addr;
    logic [32*DATA_WORDS-1:0]   r_config_data;
    logic                       r_busy;
    logic                       r_err_ovf;
    logic                       r_err_addr;
`ifdef CONFIG_BUS_FRAME_COUNT_EN
    logic [31:0]                r_frame_count;
`endif

    logic w_accept;

    assign w_accept      = s_axis_tvalid & r_tready;
    assign s_axis_tready = r_tready;
    assign config_addr   = r_config_addr;
    assign config_data   = r_config_data;
    assign busy          = r_busy;
    assign err_overflow  = r_err_ovf;
    assign err_addr      = r_err_addr;
`ifdef CONFIG_BUS_FRAME_COUNT_EN
    assign frame_count   = r_frame_count;
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state       <= S_IDLE;
            r_addr_pend   <= IDLE_ADDR;
            r_idx         <= '0;
            r_hold        <= '0;
            r_tready      <= 1'b0;
            r_config_addr <= IDLE_ADDR;
            r_config_data <= '0;
            r_busy        <= 1'b0;
            r_err_ovf     <= 1'b0;
            r_err_addr    <= 1'b0;
`ifdef CONFIG_BUS_FRAME_COUNT_EN
            r_frame_count <= '0;
`endif
        end else begin
            // Clear first; any set later in this block overrides it.
            if (clear_err) begin
                r_err_ovf  <= 1'b0;
                r_err_addr <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    r_tready <= 1'b1;
                    if (w_accept) begin
                        r_addr_pend   <= s_axis_tdata;
                        r_config_data <= '0;
                        r_idx         <= '0;
                        r_hold        <= '0;
                        r_busy        <= 1'b1;
                        if (s_axis_tlast) begin
                            r_state  <= S_PUBLISH;
                            r_tready <= 1'b0;
                        end else begin
                            r_state  <= S_COLLECT;
                        end
                    end
                end

                S_COLLECT: begin
                    if (w_accept) begin
                        // The index saturates at DATA_WORDS; excess words are dropped.
                        if (r_idx < IDX_W'(DATA_WORDS)) begin
                            for (int unsigned k = 0; k < DATA_WORDS; k++) begin
                                if (r_idx == IDX_W'(k))
                                    r_config_data[32*k +: 32] <= s_axis_tdata;
                            end
                            r_idx <= r_idx + 1'b1;
                        end else begin
                            r_err_ovf <= 1'b1;
                        end
                        if (s_axis_tlast) begin
                            r_state  <= S_PUBLISH;
                            r_tready <= 1'b0;
                            r_hold   <= '0;
                        end
                    end
                end

                S_PUBLISH: begin
                    if (r_addr_pend == IDLE_ADDR) begin
                        r_err_addr <= 1'b1;
                        r_state    <= S_GAP;
                    end else begin
                        r_config_addr <= r_addr_pend;
`ifdef CONFIG_BUS_FRAME_COUNT_EN
                        if (r_hold == '0)
                            r_frame_count <= r_frame_count + 32'd1;
`endif
                        if (r_hold == CNT_W'(HOLD_CYCLES - 1))
                            r_state <= S_GAP;
                        else
                            r_hold  <= r_hold + 1'b1;
                    end
                end

                S_GAP: begin
                    // The edge leaving GAP restores the idle address and reopens the stream.
                    r_config_addr <= IDLE_ADDR;
                    r_state       <= S_IDLE;
                    r_tready      <= 1'b1;
                    r_busy        <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_config_bus_writer.sv
module tb_config_bus_writer;

    localparam int unsigned HOLD = 2;
    localparam logic [31:0] IDLE = 32'h0000_0000;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic [31:0]  s_axis_tdata;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic         s_axis_tlast;
    logic [31:0]  config_addr;
    logic [511:0] config_data;
    logic         busy;
    logic         err_overflow;
    logic         err_addr;
    logic         clear_err;
`ifdef CONFIG_BUS_FRAME_COUNT_EN
    logic [31:0]  frame_count;
`endif

    config_bus_writer #(
        .DATA_WORDS (16),
        .HOLD_CYCLES(HOLD),
        .IDLE_ADDR  (IDLE)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tlast (s_axis_tlast),
        .config_addr  (config_addr),
        .config_data  (config_data),
        .busy         (busy),
        .err_overflow (err_overflow),
        .err_addr     (err_addr),
        .clear_err    (clear_err)
`ifdef CONFIG_BUS_FRAME_COUNT_EN
        ,
        .frame_count  (frame_count)
`endif
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    // Reference model: what the bus should show after each frame.
    logic [31:0] m_data [16];
    bit          m_ovf;
    bit          m_eaddr;
    logic [31:0] m_fc;
    logic [31:0] fq [$];

    typedef struct {
        logic [31:0] addr;
        int unsigned n;
        logic [31:0] first;
        logic [31:0] step;
        bit          gappy;
        bit          clr_before;
        bit          exp_ovf;
        bit          exp_eaddr;
    } vec_t;

    task automatic finish_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_data(input string name);
        logic [511:0] e;
        for (int k = 0; k < 16; k++) e[32*k +: 32] = m_data[k];
        checks++;
        if (config_data !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, config_data, e);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 16; k++) m_data[k] = '0;
        m_ovf = 0;
        m_eaddr = 0;
        m_fc = '0;
    endtask

    // Drive one word and return #1 after the edge that accepted it.
    task automatic send_word(input logic [31:0] d, input bit last, input bit gap);
        int unsigned wait_cnt;
        if (gap) begin
            s_axis_tvalid = 1'b0;
            @(posedge aclk); #1;
        end
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        wait_cnt = 0;
        while (s_axis_tready !== 1'b1 && wait_cnt < 100) begin
            @(posedge aclk); #1;
            wait_cnt++;
        end
        if (wait_cnt >= 100) begin
            checks++;
            errors++;
            $display("FAIL tready_timeout: got tready=%b expected 1 within 100 cycles", s_axis_tready);
            finish_run();
        end
        @(posedge aclk); #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic clear_pulse();
        clear_err = 1'b1;
        @(posedge aclk); #1;
        clear_err = 1'b0;
        m_ovf = 0;
        m_eaddr = 0;
    endtask

    // Sends address + fq, updates the model and checks publish timing.
    task automatic run_frame(input logic [31:0] addr, input bit gappy);
        int unsigned n;
        n = fq.size();
        send_word(addr, n == 0, 1'b0);
        check32("busy_after_addr", {31'b0, busy}, 32'd1);
        for (int unsigned i = 0; i < n; i++)
            send_word(fq[i], i == n - 1, gappy);

        for (int k = 0; k < 16; k++) m_data[k] = (k < n) ? fq[k] : 32'h0;
        if (n > 16) m_ovf = 1;
        if (addr == IDLE) m_eaddr = 1;
        else m_fc = m_fc + 32'd1;

        // Edge N: data final, address not yet driven, stream closed.
        check_data("data_at_tlast");
        check32("addr_at_tlast", config_addr, IDLE);
        check32("tready_at_tlast", {31'b0, s_axis_tready}, 32'd0);
        for (int unsigned c = 1; c <= HOLD; c++) begin
            @(posedge aclk); #1;
            check32("addr_hold", config_addr, (addr == IDLE) ? IDLE : addr);
            if (addr != IDLE) begin
                check32("tready_hold", {31'b0, s_axis_tready}, 32'd0);
                check32("busy_hold", {31'b0, busy}, 32'd1);
            end
        end
        @(posedge aclk); #1;
        check32("addr_after_hold", config_addr, IDLE);
        check32("tready_reopen", {31'b0, s_axis_tready}, 32'd1);
        check32("busy_done", {31'b0, busy}, 32'd0);
        check_data("data_held");
`ifdef CONFIG_BUS_FRAME_COUNT_EN
        check32("frame_count", frame_count, m_fc);
`endif
    endtask

    // config_data may only move while the address is idle.
    logic [511:0] prev_data = '0;
    always @(negedge aclk) begin
        if (config_data !== prev_data) begin
            checks++;
            if (config_addr !== IDLE) begin
                errors++;
                $display("FAIL data_stable: data changed with addr %h expected %h", config_addr, IDLE);
            end
        end
        prev_data = config_data;
    end

    initial begin
        #2_000_000;
        checks++;
        errors++;
        $display("FAIL watchdog: got no end of test expected finish before 2ms");
        finish_run();
    end

    vec_t vecs [7];

    initial begin
        vecs[0] = '{32'h0000_1001, 3,  32'h11,  32'h11, 0, 0, 0, 0};
        vecs[1] = '{32'h0000_1002, 0,  32'h0,   32'h0,  0, 0, 0, 0};
        vecs[2] = '{32'h0000_1003, 18, 32'h1,   32'h1,  0, 0, 1, 0};
        vecs[3] = '{32'h0000_1005, 2,  32'h5,   32'h1,  0, 0, 1, 0};
        vecs[4] = '{32'h0000_0000, 2,  32'h7,   32'h1,  0, 1, 0, 1};
        vecs[5] = '{32'h0000_1006, 16, 32'h100, 32'h3,  1, 1, 0, 0};
        vecs[6] = '{32'h0000_1007, 17, 32'hA0,  32'h2,  0, 0, 1, 0};

        aresetn       = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        clear_err     = 1'b0;
        model_reset();

        #12;
        check32("rst_addr", config_addr, IDLE);
        check_data("rst_data");
        check32("rst_tready", {31'b0, s_axis_tready}, 32'd0);
        check32("rst_busy", {31'b0, busy}, 32'd0);
        check32("rst_errs", {30'b0, err_overflow, err_addr}, 32'd0);
`ifdef CONFIG_BUS_FRAME_COUNT_EN
        check32("rst_frame_count", frame_count, 32'd0);
`endif
        aresetn = 1'b1;
        #1;
        check32("tready_before_edge", {31'b0, s_axis_tready}, 32'd0);
        @(posedge aclk); #1;
        check32("tready_after_release", {31'b0, s_axis_tready}, 32'd1);

        // Directed frames from the table.
        for (int v = 0; v < 7; v++) begin
            if (vecs[v].clr_before) clear_pulse();
            fq.delete();
            for (int unsigned i = 0; i < vecs[v].n; i++)
                fq.push_back(vecs[v].first + i * vecs[v].step);
            run_frame(vecs[v].addr, vecs[v].gappy);
            check32("vec_err_overflow", {31'b0, err_overflow}, {31'b0, vecs[v].exp_ovf});
            check32("vec_err_addr", {31'b0, err_addr}, {31'b0, vecs[v].exp_eaddr});
        end

        // Random frames against the model.
        for (int r = 0; r < 25; r++) begin
            logic [31:0] a;
            if ($urandom_range(0, 4) == 0) clear_pulse();
            a = ($urandom_range(0, 6) == 0) ? IDLE : ($urandom | 32'h1);
            fq.delete();
            for (int unsigned i = 0; i < $urandom_range(0, 20); i++) fq.push_back($urandom);
            repeat ($urandom_range(0, 3)) @(posedge aclk);
            #1;
            run_frame(a, $urandom_range(0, 1) == 1);
            check32("rnd_err_overflow", {31'b0, err_overflow}, {31'b0, m_ovf});
            check32("rnd_err_addr", {31'b0, err_addr}, {31'b0, m_eaddr});
        end

        // Reset during the first publish cycle.
        send_word(32'h0000_1005, 1'b0, 1'b0);
        send_word(32'h0000_0055, 1'b1, 1'b0);
        @(posedge aclk); #1;
        check32("abort_addr_driven", config_addr, 32'h0000_1005);
        #2;
        aresetn = 1'b0;
        #1;
        model_reset();
        check32("abort_addr_async", config_addr, IDLE);
        check_data("abort_data_async");
        check32("abort_busy", {31'b0, busy}, 32'd0);
        check32("abort_tready", {31'b0, s_axis_tready}, 32'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk); #1;
        fq.delete();
        fq.push_back(32'h0000_00AA);
        run_frame(32'h0000_1004, 1'b0);
        check32("post_abort_errs", {30'b0, err_overflow, err_addr}, 32'd0);

        finish_run();
    end

endmodule
